// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: branch type codes, FSM encodings and reset PC.
package kgp_pkg;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_R    = 4'd2;
  localparam logic [3:0] BR_L    = 4'd3;
  localparam logic [3:0] BR_LTZ  = 4'd4;
  localparam logic [3:0] BR_Z    = 4'd5;
  localparam logic [3:0] BR_NZ   = 4'd6;
  localparam logic [3:0] BR_CY   = 4'd7;
  localparam logic [3:0] BR_NCY  = 4'd8;

  localparam logic [31:0] KGP_RESET_PC = 32'h0000_0000;

  // HOLD waits for the first unstalled cycle, REDIRECT is the wrong-path bubble.
  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/branch_flag_unit_if.sv
// Bus between the decode/ALU side (master) and the branch/flag unit (slave).
interface branch_flag_unit_if #(
  parameter int OFF_W = 22
);
  logic             stall;
  logic             instr_valid;
  logic [3:0]       br_type;
  logic [OFF_W-1:0] br_off;
  logic [31:0]      reg_tgt;
  logic             carry_we;
  logic             alu_carry;
  logic             alu_zflag;
  logic             alu_signflag;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             taken;
  logic             link_we;
  logic [31:0]      link_data;
  logic             flush;
  logic             carry_q;

  modport master (
    output stall, instr_valid, br_type, br_off, reg_tgt,
           carry_we, alu_carry, alu_zflag, alu_signflag,
    input  pc, pc_plus4, taken, link_we, link_data, flush, carry_q
  );

  modport slave (
    input  stall, instr_valid, br_type, br_off, reg_tgt,
           carry_we, alu_carry, alu_zflag, alu_signflag,
    output pc, pc_plus4, taken, link_we, link_data, flush, carry_q
  );
endinterface

// File: rtl/branch_flag_unit_cond.sv
// Branch condition evaluator: decides whether a branch type's condition holds.
module branch_cond
  import kgp_pkg::*;
(
  input  logic [3:0] br_type,
  input  logic       signflag,
  input  logic       zflag,
  input  logic       carry,
  output logic       cond_true
);

  // Map branch type and flags to the condition result; unknown types never branch.
  always_comb begin
    cond_true = 1'b0;
    case (br_type)
      BR_B, BR_R, BR_L: cond_true = 1'b1;
      BR_LTZ:           cond_true = signflag;
      BR_Z:             cond_true = zflag;
      BR_NZ:            cond_true = ~zflag;
      BR_CY:            cond_true = carry;
      BR_NCY:           cond_true = ~carry;
      default:          cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Branch/flag unit: owns PC and carry flag, resolves KGP-RISC branches right
// after the ALU, drives link write to r31 and a one-cycle wrong-path flush.
module branch_flag_unit
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = KGP_RESET_PC,
  parameter int          OFF_W    = 22
) (
  input  logic               clk,
  input  logic               rst,
  branch_flag_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        carry_q, carry_d;
  logic        flush_q, flush_d;

  logic        cond_true_s;
  logic        active_s;
  logic        taken_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] off_ext_s;
  logic [31:0] target_s;

  branch_cond u_cond (
    .br_type   (bus.br_type),
    .signflag  (bus.alu_signflag),
    .zflag     (bus.alu_zflag),
    .carry     (carry_q),
    .cond_true (cond_true_s)
  );

  // Same-cycle branch resolution and target computation (uses the stored carry).
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    active_s   = (state_q == ST_RUN) & bus.instr_valid & ~bus.stall & ~rst;
    taken_s    = active_s & cond_true_s;
    off_ext_s  = {{(32-OFF_W){bus.br_off[OFF_W-1]}}, bus.br_off};
    if (bus.br_type == BR_R) begin
      target_s = {bus.reg_tgt[31:2], 2'b00};
    end else begin
      target_s = pc_plus4_s + {off_ext_s[29:0], 2'b00};
    end
  end

  // Next-state logic for PC, carry flag, FSM and flush; stall freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    if (!bus.stall) begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (taken_s) begin
            pc_d    = target_s;
            state_d = ST_REDIRECT;
          end else begin
            pc_d    = pc_plus4_s;
            state_d = ST_RUN;
          end
          if (active_s && bus.carry_we) begin
            carry_d = bus.alu_carry;
          end else begin
            carry_d = carry_q;
          end
        end
        ST_REDIRECT: begin
          pc_d    = pc_plus4_s;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    flush_d = (state_d == ST_REDIRECT);
  end

  // FSM and datapath registers with synchronous reset that overrides stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      pc_q    <= RESET_PC;
      carry_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4_s;
  assign bus.taken     = taken_s;
  assign bus.link_we   = taken_s & (bus.br_type == BR_L);
  assign bus.link_data = pc_plus4_s;
  assign bus.flush     = flush_q;
  assign bus.carry_q   = carry_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: directed vector table plus
// randomized traffic compared against a behavioural model.
module tb_branch_flag_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_flag_unit_if #(.OFF_W(22)) bus ();

  branch_flag_unit #(.RESET_PC(32'h0), .OFF_W(22)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, valid;
    logic [3:0]  typ;
    logic [21:0] off;
    logic [31:0] tgt;
    logic        cw, ac, z, s;
    logic        e_taken, e_link;
    logic [31:0] e_pc;
    logic        e_flush, e_carry;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // model state: PC, carry, whether the unit has left HOLD, whether a bubble is pending
  logic [31:0] m_pc;
  logic        m_carry;
  logic        m_started;
  logic        m_bubble;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, st, va, input logic [3:0] ty,
                              input logic [21:0] of, input logic [31:0] tg,
                              input logic cw, ac, z, s, tk, lk,
                              input logic [31:0] pc, input logic fl, cy);
    vec_t v;
    v.rst = r; v.stall = st; v.valid = va; v.typ = ty; v.off = of; v.tgt = tg;
    v.cw = cw; v.ac = ac; v.z = z; v.s = s; v.e_taken = tk; v.e_link = lk;
    v.e_pc = pc; v.e_flush = fl; v.e_carry = cy;
    return v;
  endfunction

  function automatic logic model_cond(input logic [3:0] ty, input logic z, s, c);
    case (ty)
      4'd1, 4'd2, 4'd3: return 1'b1;
      4'd4: return s;
      4'd5: return z;
      4'd6: return !z;
      4'd7: return c;
      4'd8: return !c;
      default: return 1'b0;
    endcase
  endfunction

  // Apply one cycle of stimulus, check against the model (and the table if use_exp).
  task automatic apply(input vec_t v, input bit use_exp);
    logic        e_taken, e_link, act;
    logic [31:0] tgt;
    int          so;
    @(negedge clk);
    rst              = v.rst;
    bus.stall        = v.stall;
    bus.instr_valid  = v.valid;
    bus.br_type      = v.typ;
    bus.br_off       = v.off;
    bus.reg_tgt      = v.tgt;
    bus.carry_we     = v.cw;
    bus.alu_carry    = v.ac;
    bus.alu_zflag    = v.z;
    bus.alu_signflag = v.s;
    #1;
    act     = !v.rst && !v.stall && m_started && !m_bubble && v.valid;
    e_taken = act && model_cond(v.typ, v.z, v.s, m_carry);
    e_link  = e_taken && (v.typ == 4'd3);
    chk("taken",     {31'd0, bus.taken},   {31'd0, e_taken});
    chk("link_we",   {31'd0, bus.link_we}, {31'd0, e_link});
    chk("link_data", bus.link_data, m_pc + 32'd4);
    chk("pc_plus4",  bus.pc_plus4,  m_pc + 32'd4);
    if (use_exp) begin
      chk("tbl_taken", {31'd0, bus.taken},   {31'd0, v.e_taken});
      chk("tbl_link",  {31'd0, bus.link_we}, {31'd0, v.e_link});
    end
    so = int'($signed(v.off));
    if (v.typ == 4'd2) tgt = v.tgt & 32'hFFFF_FFFC;
    else               tgt = m_pc + 32'd4 + 32'(so * 4);
    if (v.rst) begin
      m_pc = 32'h0; m_carry = 1'b0; m_started = 1'b0; m_bubble = 1'b0;
    end else if (v.stall) begin
      // everything holds
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_bubble) begin
      m_pc = m_pc + 32'd4; m_bubble = 1'b0;
    end else begin
      if (act && v.cw) m_carry = v.ac;
      m_pc     = e_taken ? tgt : m_pc + 32'd4;
      m_bubble = e_taken;
    end
    @(posedge clk);
    #1;
    chk("pc",      bus.pc, m_pc);
    chk("flush",   {31'd0, bus.flush},   {31'd0, m_bubble});
    chk("carry_q", {31'd0, bus.carry_q}, {31'd0, m_carry});
    if (use_exp) begin
      chk("tbl_pc",    bus.pc, v.e_pc);
      chk("tbl_flush", {31'd0, bus.flush},   {31'd0, v.e_flush});
      chk("tbl_carry", {31'd0, bus.carry_q}, {31'd0, v.e_carry});
    end
  endtask

  initial begin
    vec_t v;
    bus.stall = 1'b0; bus.instr_valid = 1'b0; bus.br_type = 4'd0; bus.br_off = 22'd0;
    bus.reg_tgt = 32'd0; bus.carry_we = 1'b0; bus.alu_carry = 1'b0;
    bus.alu_zflag = 1'b0; bus.alu_signflag = 1'b0;
    m_pc = 32'h0; m_carry = 1'b0; m_started = 1'b0; m_bubble = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    //          rst st va ty  off          tgt            cw ac z  s  tk lk pc             fl cy
    tbl.push_back(mk(1, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h4,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h8,        0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 22'd0,       32'h3F,        0, 0, 0, 0, 1, 0, 32'h3C,       1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h40,       0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 22'h3FFFFE,  32'd0,         0, 0, 1, 0, 1, 0, 32'h3C,       1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h40,       0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 22'h3FFFFE,  32'd0,         0, 0, 0, 0, 0, 0, 32'h44,       0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 22'd0,       32'hFC,        0, 0, 0, 0, 1, 0, 32'hFC,       1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h100,      0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 22'h10,      32'd0,         0, 0, 0, 0, 1, 1, 32'h144,      1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h148,      0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 22'd0,       32'h203,       0, 0, 0, 0, 1, 0, 32'h200,      1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h204,      0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 22'd0,       32'd0,         1, 1, 0, 0, 0, 0, 32'h208,      0, 1));
    tbl.push_back(mk(0, 0, 1, 7, 22'd0,       32'd0,         0, 0, 0, 0, 1, 0, 32'h20C,      1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h210,      0, 1));
    tbl.push_back(mk(0, 0, 1, 8, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h214,      0, 1));
    tbl.push_back(mk(0, 1, 1, 5, 22'h4,       32'd0,         1, 0, 1, 0, 0, 0, 32'h214,      0, 1));
    tbl.push_back(mk(0, 1, 1, 5, 22'h4,       32'd0,         1, 0, 1, 0, 0, 0, 32'h214,      0, 1));
    tbl.push_back(mk(0, 1, 1, 5, 22'h4,       32'd0,         1, 0, 1, 0, 0, 0, 32'h214,      0, 1));
    tbl.push_back(mk(0, 0, 1, 5, 22'h4,       32'd0,         0, 0, 1, 0, 1, 0, 32'h228,      1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 22'd0,       32'hFFFF_FFF8, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFF8, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 22'd0,       32'h4,         0, 0, 0, 0, 1, 0, 32'h4,        1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h8,        0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 22'h3FFFFD,  32'd0,         0, 0, 0, 0, 1, 0, 32'h0,        1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 22'd0,       32'd0,         0, 0, 0, 0, 0, 0, 32'h4,        0, 0));

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    for (int n = 0; n < 600; n++) begin
      v.rst   = ($urandom_range(0, 63) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.valid = ($urandom_range(0, 4) != 0);
      v.typ   = 4'($urandom_range(0, 15));
      v.off   = 22'($urandom);
      v.tgt   = $urandom;
      v.cw    = 1'($urandom);
      v.ac    = 1'($urandom);
      v.z     = 1'($urandom);
      v.s     = 1'($urandom);
      v.e_taken = 1'b0; v.e_link = 1'b0; v.e_pc = 32'd0; v.e_flush = 1'b0; v.e_carry = 1'b0;
      apply(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
